// File: rtl/block_code_scheduler.sv
// Job controller in front of the block-code decoder: round-robin job arbitration,
// one-shot decoder configuration, fixed-length symbol feed and tagged bit drain.
module block_code_scheduler #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_SYMBOLS   = 20,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            req0_code_length,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [7:0]            req1_code_length,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  output logic [7:0]            cfg_code_length,
  output logic                  cfg_code_length_valid,
  output logic [DATA_WIDTH-1:0] dec_s_axis_tdata,
  output logic                  dec_s_axis_tvalid,
  output logic                  dec_s_axis_tlast,
  input  logic                  dec_s_axis_tready,
  input  logic                  dec_m_axis_tdata,
  input  logic                  dec_m_axis_tvalid,
  input  logic                  dec_m_axis_tlast,
  output logic                  dec_m_axis_tready,
  output logic                  m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  sym_err,
  output logic                  len_err,
  output logic                  timeout
);

  localparam int SYM_W = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;
  localparam int WD_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(NUM_SYMBOLS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, CFG, FEED, DRAIN} state_t;

  state_t           state_q;
  logic             rr_last_q;
  logic             id_q;
  logic [7:0]       cfg_len_q;
  logic             cfg_valid_q;
  logic [SYM_W-1:0] sym_cnt_q;
  logic [7:0]       bit_cnt_q;
  logic [WD_W-1:0]  wd_cnt_q;
  logic             cfg_err_q;
  logic             sym_err_q;
  logic             len_err_q;
  logic             timeout_q;

  logic                  grant_id;
  logic [7:0]            grant_len;
  logic                  len_ok;
  logic                  accept;
  logic                  in_feed;
  logic                  in_drain;
  logic                  up_valid;
  logic                  up_last;
  logic [DATA_WIDTH-1:0] up_data;
  logic                  sym_hs;
  logic                  sym_last;
  logic                  bit_hs;
  logic                  wd_hit;

  // On a tie the requester that did not win last time is granted.
  assign grant_id  = (req0_valid && req1_valid) ? ~rr_last_q : req1_valid;
  assign grant_len = grant_id ? req1_code_length : req0_code_length;
  assign len_ok    = (grant_len >= 8'd2) && (grant_len <= 8'd7);
  assign accept    = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  assign in_feed  = (state_q == FEED);
  assign in_drain = (state_q == DRAIN);

  assign up_valid = id_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign up_last  = id_q ? s1_axis_tlast  : s0_axis_tlast;
  assign up_data  = id_q ? s1_axis_tdata  : s0_axis_tdata;
  assign sym_last = (sym_cnt_q == LAST_SYM);

  assign dec_s_axis_tvalid = in_feed && up_valid;
  assign dec_s_axis_tdata  = in_feed ? up_data : '0;
  assign dec_s_axis_tlast  = in_feed && sym_last;
  assign s0_axis_tready    = in_feed && !id_q && dec_s_axis_tready;
  assign s1_axis_tready    = in_feed && id_q && dec_s_axis_tready;
  assign sym_hs            = dec_s_axis_tvalid && dec_s_axis_tready;

  assign m_axis_tvalid     = in_drain && dec_m_axis_tvalid;
  assign m_axis_tdata      = in_drain && dec_m_axis_tdata;
  assign m_axis_tlast      = in_drain && dec_m_axis_tlast;
  assign m_axis_tuser      = id_q;
  assign dec_m_axis_tready = in_drain && m_axis_tready;
  assign bit_hs            = m_axis_tvalid && m_axis_tready;

  assign wd_hit = (DRAIN_TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

  assign busy                  = (state_q != IDLE);
  assign cfg_code_length       = cfg_len_q;
  assign cfg_code_length_valid = cfg_valid_q;
  assign cfg_err               = cfg_err_q;
  assign sym_err               = sym_err_q;
  assign len_err               = len_err_q;
  assign timeout               = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      id_q        <= 1'b0;
      cfg_len_q   <= 8'd0;
      cfg_valid_q <= 1'b0;
      sym_cnt_q   <= '0;
      bit_cnt_q   <= 8'd0;
      wd_cnt_q    <= '0;
      cfg_err_q   <= 1'b0;
      sym_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      sym_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            rr_last_q <= grant_id;
            id_q      <= grant_id;
            // Out-of-range lengths are consumed but never reach the decoder.
            if (len_ok) begin
              cfg_len_q   <= grant_len;
              cfg_valid_q <= 1'b1;
              state_q     <= CFG;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        CFG: state_q <= FEED;
        FEED: begin
          if (sym_hs) begin
            sym_err_q <= (up_last != sym_last);
            if (sym_last) begin
              sym_cnt_q <= '0;
              bit_cnt_q <= 8'd0;
              wd_cnt_q  <= '0;
              state_q   <= DRAIN;
            end else begin
              sym_cnt_q <= sym_cnt_q + SYM_W'(1);
            end
          end
        end
        DRAIN: begin
          if (bit_hs && dec_m_axis_tlast) begin
            len_err_q <= (({1'b0, bit_cnt_q} + 9'd1) != {1'b0, cfg_len_q});
            bit_cnt_q <= 8'd0;
            wd_cnt_q  <= '0;
            state_q   <= IDLE;
          end else begin
            if (bit_hs) bit_cnt_q <= bit_cnt_q + 8'd1;
            if (wd_hit) begin
              timeout_q <= 1'b1;
              bit_cnt_q <= 8'd0;
              wd_cnt_q  <= '0;
              state_q   <= IDLE;
            end else begin
              wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_code_scheduler.sv
// Directed bench for block_code_scheduler: arbitration, feed/drain framing,
// error pulses, drain watchdog (50 cycles) and reset mid-job.
module tb_block_code_scheduler;

  localparam int NS = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req0_code_length, req1_code_length;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] s0_axis_tdata, s1_axis_tdata;
  logic       s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic       s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic [7:0] cfg_code_length;
  logic       cfg_code_length_valid;
  logic [7:0] dec_s_axis_tdata;
  logic       dec_s_axis_tvalid, dec_s_axis_tlast, dec_s_axis_tready;
  logic       dec_m_axis_tdata, dec_m_axis_tvalid, dec_m_axis_tlast, dec_m_axis_tready;
  logic       m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic       busy, cfg_err, sym_err, len_err, timeout;

  int   checks = 0;
  int   errors = 0;
  logic sym_pending;

  always #5 clk = ~clk;

  block_code_scheduler #(.DATA_WIDTH(8), .NUM_SYMBOLS(NS), .DRAIN_TIMEOUT(50)) dut (
    .clk(clk), .rst(rst),
    .req0_code_length(req0_code_length), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_code_length(req1_code_length), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .cfg_code_length(cfg_code_length), .cfg_code_length_valid(cfg_code_length_valid),
    .dec_s_axis_tdata(dec_s_axis_tdata), .dec_s_axis_tvalid(dec_s_axis_tvalid),
    .dec_s_axis_tlast(dec_s_axis_tlast), .dec_s_axis_tready(dec_s_axis_tready),
    .dec_m_axis_tdata(dec_m_axis_tdata), .dec_m_axis_tvalid(dec_m_axis_tvalid),
    .dec_m_axis_tlast(dec_m_axis_tlast), .dec_m_axis_tready(dec_m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .busy(busy), .cfg_err(cfg_err), .sym_err(sym_err), .len_err(len_err), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds reset for one edge with every input active, checks all outputs are 0.
  task automatic reset_check();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1; s0_axis_tlast = 1'b1; s1_axis_tlast = 1'b1;
    dec_s_axis_tready = 1'b1; m_axis_tready = 1'b1;
    dec_m_axis_tvalid = 1'b1; dec_m_axis_tlast = 1'b1; dec_m_axis_tdata = 1'b1;
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_cfg_len", cfg_code_length, 0);
    chk("rst_cfg_valid", cfg_code_length_valid, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_s_tready", {s0_axis_tready, s1_axis_tready}, 0);
    chk("rst_dec_s", {dec_s_axis_tvalid, dec_s_axis_tlast, dec_s_axis_tdata}, 0);
    chk("rst_dec_m_ready", dec_m_axis_tready, 0);
    chk("rst_m_axis", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser}, 0);
    chk("rst_err_flags", {cfg_err, sym_err, len_err, timeout}, 0);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    dec_m_axis_tvalid = 1'b0; dec_m_axis_tlast = 1'b0;
  endtask

  // Called positioned at a sample point; checks the grant and the CFG cycle after it.
  task automatic wait_grant(input int exp_id, input logic [7:0] exp_len, input int exp_wait);
    int w = 0;
    while (!(req0_ready || req1_ready) && w < 100) begin
      @(negedge clk); #1;
      w++;
    end
    chk("grant_seen", req0_ready | req1_ready, 1);
    chk("grant_id", req1_ready, exp_id[0]);
    chk("grant_other", (exp_id != 0) ? req0_ready : req1_ready, 0);
    if (exp_wait >= 0) chk("grant_latency", w, exp_wait);
    @(negedge clk); #1;
    chk("cfg_valid", cfg_code_length_valid, 1);
    chk("cfg_len", cfg_code_length, exp_len);
    chk("cfg_busy", busy, 1);
    chk("cfg_no_feed", dec_s_axis_tvalid, 0);
  endtask

  task automatic feed(input int id, input int upl_beat, input bit thr, input int nbeats);
    int k = 0;
    int cyc = 0;
    logic rdy;
    logic exp_err = 1'b0;
    logic [7:0] exp_data;
    while (k < nbeats && cyc < 400) begin
      @(negedge clk);
      rdy = thr ? ((cyc % 30) >= 20) : 1'b1;
      dec_s_axis_tready = rdy;
      s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1;
      s0_axis_tdata = 8'(k + 1);
      s1_axis_tdata = 8'(128 + k);
      s0_axis_tlast = (id == 0) ? (k == upl_beat) : 1'b1;
      s1_axis_tlast = (id == 1) ? (k == upl_beat) : 1'b1;
      exp_data = (id == 0) ? 8'(k + 1) : 8'(128 + k);
      #1;
      if (cyc == 0) chk("cfg_pulse_once", cfg_code_length_valid, 0);
      chk("sym_err", sym_err, exp_err);
      chk("feed_valid", dec_s_axis_tvalid, 1);
      chk("feed_tready", (id == 0) ? s0_axis_tready : s1_axis_tready, rdy);
      chk("feed_other_tready", (id == 0) ? s1_axis_tready : s0_axis_tready, 0);
      if (rdy) begin
        chk("feed_data", dec_s_axis_tdata, exp_data);
        chk("feed_tlast", dec_s_axis_tlast, (k == NS - 1));
        exp_err = ((k == upl_beat) != (k == NS - 1));
        k++;
      end else begin
        exp_err = 1'b0;
      end
      cyc++;
    end
    chk("feed_done", k, nbeats);
    sym_pending = exp_err;
  endtask

  task automatic drain(input int id, input int nbits, input bit thr, input logic exp_len_err);
    int j = 0;
    int cyc = 0;
    logic rdy;
    logic done = 1'b0;
    logic bitv;
    while (!done && cyc < 45) begin
      @(negedge clk);
      rdy = thr ? ((cyc % 30) >= 20) : 1'b1;
      bitv = (((j * 5 + id) % 3) == 0);
      m_axis_tready = rdy;
      dec_m_axis_tvalid = 1'b1;
      dec_m_axis_tdata = bitv;
      dec_m_axis_tlast = (j == nbits - 1);
      #1;
      if (cyc == 0) begin
        chk("sym_err_last_beat", sym_err, sym_pending);
        chk("drain_no_feed", dec_s_axis_tvalid, 0);
      end
      chk("drain_valid", m_axis_tvalid, 1);
      chk("drain_data", m_axis_tdata, bitv);
      chk("drain_tlast", m_axis_tlast, (j == nbits - 1));
      chk("drain_tuser", m_axis_tuser, id[0]);
      chk("drain_dec_ready", dec_m_axis_tready, rdy);
      if (rdy) begin
        if (j == nbits - 1) done = 1'b1;
        j++;
      end
      cyc++;
    end
    chk("drain_done", done, 1);
    @(negedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("len_err", len_err, exp_len_err);
    chk("idle_no_timeout", timeout, 0);
    chk("idle_m_valid", m_axis_tvalid, 0);
    chk("idle_dec_m_ready", dec_m_axis_tready, 0);
    dec_m_axis_tvalid = 1'b0;
    dec_m_axis_tlast = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    req0_code_length = 8'd0; req1_code_length = 8'd0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    s0_axis_tdata = 8'd0; s1_axis_tdata = 8'd0;
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1;
    s0_axis_tlast = 1'b0; s1_axis_tlast = 1'b0;
    dec_s_axis_tready = 1'b1;
    dec_m_axis_tdata = 1'b0; dec_m_axis_tvalid = 1'b0; dec_m_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    sym_pending = 1'b0;

    reset_check();

    // Single job on req0, length 5.
    @(negedge clk);
    req0_code_length = 8'd5; req0_valid = 1'b1;
    #1;
    wait_grant(0, 8'd5, 0);
    req0_valid = 1'b0;
    feed(0, NS - 1, 1'b0, NS);
    drain(0, 5, 1'b0, 1'b0);

    // Arbitration after reset: 0, then 1, then 0, back to back.
    reset_check();
    @(negedge clk);
    req0_code_length = 8'd3; req1_code_length = 8'd7;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    wait_grant(0, 8'd3, 0);
    feed(0, NS - 1, 1'b0, NS);
    drain(0, 3, 1'b0, 1'b0);
    wait_grant(1, 8'd7, 0);
    feed(1, NS - 1, 1'b0, NS);
    drain(1, 7, 1'b0, 1'b0);
    wait_grant(0, 8'd3, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    feed(0, NS - 1, 1'b0, NS);
    drain(0, 3, 1'b0, 1'b0);

    // Out-of-range length is accepted then dropped.
    @(negedge clk);
    req1_code_length = 8'd9; req1_valid = 1'b1;
    #1;
    chk("bad_len_ready", req1_ready, 1);
    chk("bad_len_other", req0_ready, 0);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("cfg_err", cfg_err, 1);
    chk("bad_len_no_cfg", cfg_code_length_valid, 0);
    chk("bad_len_idle", busy, 0);
    chk("bad_len_no_stream", s1_axis_tready, 0);
    chk("cfg_len_hold", cfg_code_length, 3);
    @(negedge clk); #1;
    chk("cfg_err_one_cycle", cfg_err, 0);

    // Upstream tlast on symbol 12 (and missing on symbol 20).
    @(negedge clk);
    req0_code_length = 8'd6; req0_valid = 1'b1;
    #1;
    wait_grant(0, 8'd6, 0);
    req0_valid = 1'b0;
    feed(0, 11, 1'b0, NS);
    drain(0, 6, 1'b0, 1'b0);

    // Decoder ends after 4 bits on a length-6 job.
    @(negedge clk);
    req1_code_length = 8'd6; req1_valid = 1'b1;
    #1;
    wait_grant(1, 8'd6, 0);
    req1_valid = 1'b0;
    feed(1, NS - 1, 1'b0, NS);
    drain(1, 4, 1'b0, 1'b1);

    // No decoder output: watchdog fires after 50 DRAIN cycles.
    @(negedge clk);
    req0_code_length = 8'd2; req0_valid = 1'b1;
    #1;
    wait_grant(0, 8'd2, 0);
    req0_valid = 1'b0;
    feed(0, NS - 1, 1'b0, NS);
    cnt = 0;
    @(negedge clk); #1;
    while (!timeout && cnt < 200) begin
      cnt++;
      @(negedge clk); #1;
    end
    chk("timeout_cycles", cnt, 50);
    chk("timeout_idle", busy, 0);
    chk("timeout_no_len_err", len_err, 0);
    @(negedge clk); #1;
    chk("timeout_one_cycle", timeout, 0);

    // Length sweep with both stream sides throttled 20 low / 10 high.
    for (int len = 2; len <= 7; len++) begin
      @(negedge clk);
      if ((len % 2) == 0) begin
        req0_code_length = 8'(len); req0_valid = 1'b1;
      end else begin
        req1_code_length = 8'(len); req1_valid = 1'b1;
      end
      #1;
      wait_grant(len % 2, 8'(len), 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      feed(len % 2, NS - 1, 1'b1, NS);
      drain(len % 2, len, 1'b1, 1'b0);
    end
    m_axis_tready = 1'b1;
    dec_s_axis_tready = 1'b1;

    // Reset in the middle of FEED, then a clean job (tie goes to req0 again).
    @(negedge clk);
    req1_code_length = 8'd4; req1_valid = 1'b1;
    #1;
    wait_grant(1, 8'd4, 0);
    req1_valid = 1'b0;
    feed(1, NS - 1, 1'b0, 8);
    reset_check();
    @(negedge clk);
    req0_code_length = 8'd5; req1_code_length = 8'd3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    wait_grant(0, 8'd5, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    feed(0, NS - 1, 1'b0, NS);
    drain(0, 5, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_code_scheduler.md
Name: block_code_scheduler

Overview:
- Job controller in front of top_block_code. Arbitrates decode jobs from two requesters (round-robin) and programs code_length for each job.
- Feeds exactly NUM_SYMBOLS 8-bit soft symbols from the granted requester into the decoder, then drains the decoded bits tagged with the requester id.
- Allows one job in flight at a time. The decoder is never reconfigured mid-job.

Parameters:
- DATA_WIDTH, 8, soft-symbol width.
- NUM_SYMBOLS, 20, symbols per codeword fed to the decoder.
- DRAIN_TIMEOUT, 4096, maximum cycles in DRAIN before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- reqN_code_length  in  8  job code length, N=0,1.
- reqN_valid  in  1  job request, N=0,1.
- reqN_ready  out  1  job accept pulse, N=0,1.
- sN_axis_tdata  in  DATA_WIDTH  requester symbol stream, N=0,1.
- sN_axis_tvalid  in  1, N=0,1.
- sN_axis_tlast  in  1, N=0,1.
- sN_axis_tready  out  1, N=0,1.
- cfg_code_length  out  8  to decoder code_length.
- cfg_code_length_valid  out  1  to decoder code_length_valid.
- dec_s_axis_tdata  out  DATA_WIDTH.
- dec_s_axis_tvalid  out  1.
- dec_s_axis_tlast  out  1.
- dec_s_axis_tready  in  1.
- dec_m_axis_tdata  in  1  decoded bit from the decoder.
- dec_m_axis_tvalid  in  1.
- dec_m_axis_tlast  in  1.
- dec_m_axis_tready  out  1.
- m_axis_tdata  out  1.
- m_axis_tvalid  out  1.
- m_axis_tlast  out  1.
- m_axis_tuser  out  1  requester id of the current job.
- m_axis_tready  in  1.
- busy  out  1  high when the FSM is not in IDLE.
- cfg_err  out  1  one-cycle pulse: rejected code_length.
- sym_err  out  1  one-cycle pulse: upstream tlast misaligned.
- len_err  out  1  one-cycle pulse: decoded length mismatch.
- timeout  out  1  one-cycle pulse: drain watchdog expired.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE; all counters clear; rr_last=1, so req0 wins the first tie.
  - Every output is 0, including cfg_code_length.
  - Reset mid-job abandons the job; no error pulses are generated.
- FSM states: IDLE, CFG, FEED, DRAIN.
- IDLE, arbitration:
  - If any reqN_valid is high, grant one. With both high, grant the requester != rr_last.
  - In the same cycle: reqN_ready=1 for one cycle, latch code_length and id, set rr_last=id.
  - Valid code_length is 2..7. Out-of-range is accepted (reqN_ready pulses) but the job is dropped: cfg_err pulses the next cycle, FSM stays IDLE, rr_last still updates.
  - Valid job -> CFG.
- CFG:
  - cfg_code_length_valid=1 for exactly one cycle.
  - cfg_code_length holds the latched value from CFG until the next CFG.
  - Next state FEED.
- FEED:
  - dec_s_axis_tdata/tvalid are muxed combinationally from the granted sN_axis.
  - sN_axis_tready = dec_s_axis_tready for the granted N; the non-granted tready = 0.
  - sym_cnt increments on each dec_s handshake.
  - dec_s_axis_tlast is generated internally: 1 when sym_cnt==NUM_SYMBOLS-1. Upstream tlast is not forwarded.
  - sym_err pulses (registered, one cycle after the handshake) if upstream tlast=1 with sym_cnt!=NUM_SYMBOLS-1, or tlast=0 on the last beat. Feeding continues in either case.
  - After the NUM_SYMBOLS-th handshake -> DRAIN; sym_cnt clears.
- DRAIN:
  - m_axis_tdata/tvalid/tlast pass combinationally from dec_m_axis_*; dec_m_axis_tready = m_axis_tready.
  - m_axis_tuser = latched id.
  - bit_cnt increments per m_axis handshake. On the tlast handshake: len_err pulses next cycle if bit_cnt+1 != code_length; FSM -> IDLE.
  - Watchdog counts cycles in DRAIN. When it reaches DRAIN_TIMEOUT, timeout pulses and FSM -> IDLE.
- Outside DRAIN: m_axis_tvalid=0 and dec_m_axis_tready=0.
- Outside FEED: dec_s_axis_tvalid=0 and both sN_axis_tready=0.
- Latency: request accept (cycle T) -> cfg valid at T+1 -> first symbol accepted no earlier than T+2. The next job may be accepted the cycle after the DRAIN tlast handshake.
- Requests arriving while busy are held off (reqN_ready=0). reqN_valid must stay high until accepted.
- Simultaneous events: a new reqN_valid rising in the cycle the FSM returns to IDLE is arbitrated on the next cycle. Error pulses are independent and may coincide.

Test Plan:
- Single job, code_length=5 on req0, 20 symbols, sink always ready -> cfg_code_length_valid one cycle with value 5; dec_s_axis_tlast on beat 20 only; 5 decoded bits out with tuser=0; tlast on bit 5; no error flags.
- Both requesters valid after reset with lengths 3 and 7 -> req0 granted first, then req1; with both still requesting, grants alternate 0,1,0; tuser matches each job's grant.
- req1 code_length=9 -> req1_ready pulses, cfg_err one cycle, cfg_code_length_valid stays 0, no stream traffic.
- Upstream tlast on symbol 12 -> sym_err one cycle after that beat; 20 symbols still forwarded; decoder tlast on beat 20.
- Decoder returns tlast after 4 bits for code_length=6 -> len_err one cycle; FSM back to IDLE. With DRAIN_TIMEOUT=50 and no decoder output -> timeout after 50 cycles.
- Sweep code_length 2..7; ready low 20 cycles / high 10 cycles on both stream sides; rst asserted mid-FEED -> all outputs 0 next cycle, and the next job completes correctly.
